// File: rtl/cpu_package.sv
// rtl/cpu_package.sv - shared widths, register-file constants and enums for the execute stage
package cpu_package;

    localparam int WORD_WIDTH    = 8;
    localparam int NUM_REGS      = 8;
    localparam int REG_IDX_WIDTH = 3;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRead = 2'b01,
        StExec = 2'b10,
        StWb   = 2'b11
    } Type_exec_state;

    typedef enum logic [1:0] {
        MOV = 2'b00,
        ADD = 2'b01,
        SUB = 2'b10,
        SHL = 2'b11
    } Type_opcode;

endpackage

// File: rtl/exec_regfile.sv
// rtl/exec_regfile.sv - register file with two captured read ports, one write port and a debug read
module exec_regfile
    import cpu_package::*;
#(
    parameter int WORD_WIDTH = cpu_package::WORD_WIDTH,
    parameter int NUM_REGS   = cpu_package::NUM_REGS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rd_en,
    input  logic [REG_IDX_WIDTH-1:0] rd_addr_a,
    input  logic [REG_IDX_WIDTH-1:0] rd_addr_b,
    output logic [WORD_WIDTH-1:0]    rd_data_a,
    output logic [WORD_WIDTH-1:0]    rd_data_b,
    input  logic                     wr_en,
    input  logic [REG_IDX_WIDTH-1:0] wr_addr,
    input  logic [WORD_WIDTH-1:0]    wr_data,
    input  logic [REG_IDX_WIDTH-1:0] dbg_addr,
    output logic [WORD_WIDTH-1:0]    dbg_data
);

    logic [WORD_WIDTH-1:0] mem [NUM_REGS];

    // Each register comes out of reset holding its own index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= WORD_WIDTH'(i);
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else if (rd_en) begin
            rd_data_a <= mem[rd_addr_a];
            rd_data_b <= mem[rd_addr_b];
        end
    end

    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - execute/write-back FSM and ALU; optional flags under EXEC_STAGE_FLAGS_EN
module exec_stage
    import cpu_package::*;
#(
    parameter int WORD_WIDTH = cpu_package::WORD_WIDTH,
    parameter int NUM_REGS   = cpu_package::NUM_REGS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               op_code,
    input  logic [REG_IDX_WIDTH-1:0] reg_or,
    input  logic [REG_IDX_WIDTH-1:0] reg_dest,
    output logic                     wb_valid,
    output logic [REG_IDX_WIDTH-1:0] wb_addr,
    output logic [WORD_WIDTH-1:0]    wb_data,
    input  logic [REG_IDX_WIDTH-1:0] dbg_addr,
    output logic [WORD_WIDTH-1:0]    dbg_data
`ifdef EXEC_STAGE_FLAGS_EN
    ,
    output logic                     flag_z,
    output logic                     flag_c
`endif
);

    // The ALU result carries one extra bit only when the carry flag needs it.
`ifdef EXEC_STAGE_FLAGS_EN
    localparam int ALU_W = WORD_WIDTH + 1;
`else
    localparam int ALU_W = WORD_WIDTH;
`endif

    Type_exec_state           state, next_state;
    Type_opcode               op_q;
    logic [REG_IDX_WIDTH-1:0] or_q, dest_q;
    logic [WORD_WIDTH-1:0]    opa, opb, result_q;
    logic [ALU_W-1:0]         alu_next;
    logic                     accept, rd_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= StIdle;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        rd_en      = 1'b0;
        wb_valid   = 1'b0;
        case (state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) next_state = StRead;
            end
            StRead: begin
                rd_en      = 1'b1;
                next_state = StExec;
            end
            StExec:  next_state = StWb;
            StWb: begin
                wb_valid   = 1'b1;
                next_state = StIdle;
            end
            default: next_state = StIdle;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        alu_next = '0;
        case (op_q)
            MOV:     alu_next = ALU_W'(opb);
            ADD:     alu_next = ALU_W'(opa) + ALU_W'(opb);
            SUB:     alu_next = ALU_W'(opa) - ALU_W'(opb);
            SHL:     alu_next = ALU_W'({opa, 1'b0});
            default: alu_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= MOV;
            or_q     <= '0;
            dest_q   <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q   <= Type_opcode'(op_code);
                or_q   <= reg_or;
                dest_q <= reg_dest;
            end
            if (state == StExec) begin
                result_q <= alu_next[WORD_WIDTH-1:0];
            end
        end
    end

`ifdef EXEC_STAGE_FLAGS_EN
    logic carry_q;

    // Carry is captured alongside the result so the flags settle on the write-back edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carry_q <= 1'b0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
        end else begin
            if (state == StExec) carry_q <= alu_next[WORD_WIDTH];
            if (state == StWb) begin
                flag_z <= (result_q == '0);
                flag_c <= carry_q;
            end
        end
    end
`endif

    assign wb_addr = wb_valid ? dest_q : '0;
    assign wb_data = wb_valid ? result_q : '0;

    exec_regfile #(
        .WORD_WIDTH (WORD_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .rd_en     (rd_en),
        .rd_addr_a (dest_q),
        .rd_addr_b (or_q),
        .rd_data_a (opa),
        .rd_data_b (opb),
        .wr_en     (wb_valid),
        .wr_addr   (dest_q),
        .wr_data   (result_q),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

endmodule

// File: tb/tb_exec_stage.sv
// tb/tb_exec_stage.sv - randomized self-checking bench for exec_stage against an arithmetic register model
module tb_exec_stage;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] op_code = 2'd0;
    logic [2:0] reg_or = 3'd0;
    logic [2:0] reg_dest = 3'd0;
    logic       wb_valid;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;
    logic [2:0] dbg_addr = 3'd0;
    logic [7:0] dbg_data;
`ifdef EXEC_STAGE_FLAGS_EN
    logic       flag_z, flag_c;
`endif

    int total = 0;
    int bad = 0;
    int model_reg [8];
    int model_z = 0;
    int model_c = 0;

    exec_stage #(.WORD_WIDTH(8), .NUM_REGS(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_code  (op_code),
        .reg_or   (reg_or),
        .reg_dest (reg_dest),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`ifdef EXEC_STAGE_FLAGS_EN
        ,
        .flag_z   (flag_z),
        .flag_c   (flag_c)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model_reg[i] = i;
        model_z = 0;
        model_c = 0;
    endtask

    task automatic model_exec(input int op, input int rd, input int rs, output int res);
        int a, b, raw;
        a = model_reg[rd];
        b = model_reg[rs];
        case (op)
            0: begin raw = b;     model_c = 0;                 end
            1: begin raw = a + b; model_c = (raw > 255) ? 1 : 0; end
            2: begin raw = a - b; model_c = (a < b) ? 1 : 0;   end
            default: begin raw = a * 2; model_c = (a >= 128) ? 1 : 0; end
        endcase
        res = raw % 256;
        if (res < 0) res += 256;
        model_z = (res == 0) ? 1 : 0;
        model_reg[rd] = res;
    endtask

    task automatic check_flags(input string tag);
`ifdef EXEC_STAGE_FLAGS_EN
        check({tag, "_flag_z"}, flag_z, model_z);
        check({tag, "_flag_c"}, flag_c, model_c);
`endif
    endtask

    task automatic dbg_sweep(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = i[2:0];
            #1;
            check($sformatf("%s_dbg%0d", tag, i), dbg_data, model_reg[i]);
        end
    endtask

    // Called at a negedge with the stage idle; returns at the idle negedge after write-back.
    task automatic issue(input int op, input int rd, input int rs, input bit hold);
        int exp;
        in_valid = 1'b1;
        op_code  = op[1:0];
        reg_dest = rd[2:0];
        reg_or   = rs[2:0];
        check("ready_before_accept", in_ready, 1);
        model_exec(op, rd, rs, exp);
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (hold) begin
                op_code  = 2'($urandom);
                reg_dest = 3'($urandom);
                reg_or   = 3'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            check($sformatf("busy_ready_c%0d", k), in_ready, 0);
            check($sformatf("wb_valid_c%0d", k), wb_valid, (k == 3) ? 1 : 0);
            if (k == 3) begin
                check("wb_addr", wb_addr, rd);
                check("wb_data", wb_data, exp);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("ready_after_wb", in_ready, 1);
        check("wb_valid_after", wb_valid, 0);
        dbg_addr = rd[2:0];
        #1;
        check("dbg_dest", dbg_data, model_reg[rd]);
        check_flags("post_wb");
        dbg_addr = 3'($urandom_range(0, 7));
        #1;
        check("dbg_rand", dbg_data, model_reg[dbg_addr]);
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_data", wb_data, 0);
        check_flags("rst");
        dbg_sweep("rst");
        @(negedge clk);
        reset = 1'b1;

        issue(1, 2, 3, 1'b0);
        issue(2, 1, 4, 1'b0);
        for (int i = 0; i < 5; i++) issue(3, 4, 4, 1'b0);
        issue(0, 7, 4, 1'b0);
        issue(3, 7, 7, 1'b0);
        issue(1, 6, 6, 1'b1);
        issue(2, 0, 5, 1'b1);
        issue(1, 3, 2, 1'b0);

        // Reset during StExec of MOV r5 <- r0.
        in_valid = 1'b1;
        op_code  = 2'd0;
        reg_dest = 3'd5;
        reg_or   = 3'd0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_wb_valid", wb_valid, 0);
        check("midrst_wb_data", wb_data, 0);
        check_flags("midrst");
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst_no_wb", wb_valid, 0);
            check("midrst_idle", in_ready, 1);
        end
        dbg_sweep("midrst");

        for (int n = 0; n < 150; n++) begin
            issue($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
                  ($urandom_range(0, 3) == 0));
        end
        dbg_sweep("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
